// File: rtl/meter_pkg.sv
// Shared parking-meter definitions: hour band boundaries, rate constants,
// FSM state encoding and the rate lookup used by both conversion directions
// (cost -> time and time -> cost), so the two never disagree on band edges.
package meter_pkg;

  // Hour band boundaries (hour field is 5 bits; 24..31 are invalid).
  localparam logic [4:0] HOUR_8  = 5'd8;
  localparam logic [4:0] HOUR_13 = 5'd13;
  localparam logic [4:0] HOUR_18 = 5'd18;
  localparam logic [4:0] HOUR_24 = 5'd24;

  // The one location with its own tariff.
  localparam logic [2:0] LOC_PREMIUM = 3'd6;

  // Rates in cents/min x 100.
  localparam logic [7:0] RATE_STD_LO   = 8'd100;
  localparam logic [7:0] RATE_STD_HI   = 8'd200;
  localparam logic [7:0] RATE_L6_NIGHT = 8'd134;
  localparam logic [7:0] RATE_L6_AM    = 8'd156;
  localparam logic [7:0] RATE_L6_PM    = 8'd178;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_ADD  = 2'd2
  } purchase_state_t;

  function automatic logic hour_valid(input logic [4:0] hour);
    return hour < HOUR_24;
  endfunction

  // Hours 24..31 land in the last band here; callers gate with hour_valid.
  function automatic logic [7:0] rate_lookup(input logic [2:0] loc,
                                             input logic [4:0] hour);
    logic [7:0] r;
    if (loc == LOC_PREMIUM) begin
      if (hour < HOUR_8)       r = RATE_L6_NIGHT;
      else if (hour < HOUR_13) r = RATE_L6_AM;
      else if (hour < HOUR_18) r = RATE_L6_PM;
      else                     r = RATE_L6_AM;
    end else begin
      if (hour < HOUR_8)       r = RATE_STD_LO;
      else if (hour < HOUR_18) r = RATE_STD_HI;
      else                     r = RATE_STD_LO;
    end
    return r;
  endfunction

endpackage

// File: rtl/meter_time_purchase_seq_divider.sv
// seq_divider: restoring radix-2 divider, one quotient bit per clock.
//   clk, rst_n   clock / async active-low reset
//   start        load dividend/divisor and begin (ignored while abort is high)
//   abort        drop any division in progress
//   dividend     DIV_W-bit dividend
//   divisor      8-bit divisor (non-zero)
//   quotient     floor(dividend / divisor), valid the cycle after done
//   done         high during the final iteration cycle
// A division takes exactly DIV_W cycles after the start edge.
module seq_divider #(
  parameter int DIV_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] dividend,
  input  logic [7:0]       divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] quo;
  logic [7:0]       rem;
  logic [7:0]       dvsr;
  logic [CNT_W-1:0] cnt;

  logic [8:0] rem_shift;
  logic       take;
  logic [7:0] rem_next;

  // Remainder stays below the divisor, so the shifted value fits 9 bits and
  // the restored/subtracted remainder always fits back into 8.
  always_comb begin
    rem_shift = {rem, quo[DIV_W-1]};
    take      = rem_shift >= {1'b0, dvsr};
    rem_next  = take ? 8'(rem_shift - {1'b0, dvsr}) : rem_shift[7:0];
  end

  // cnt is a down-counter of remaining iterations; 0 means idle.
  assign done     = (cnt == CNT_W'(1));
  assign quotient = quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
      cnt  <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
      cnt  <= CNT_W'(DIV_W);
    end else if (cnt != '0) begin
      quo <= {quo[DIV_W-2:0], take};
      rem <= rem_next;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/meter_time_purchase.sv
// meter_time_purchase: converts deposited coins into parking seconds at the
// current location/hour rate and keeps a saturating 1 Hz countdown.
//   clk, rst_n    clock / async active-low reset
//   sw            [7:5] location, [4:0] hour (0..23 valid)
//   coin_valid    coin present this cycle
//   coin_cents    coin value in cents
//   coin_ready    coin can be accepted
//   coin_reject   one-cycle pulse: coin dropped, hour invalid
//   tick_1hz      one-cycle pulse per second
//   clear         synchronous clear of purchased time (aborts conversion)
//   sec_left      purchased seconds remaining
//   expired       registered, high when sec_left == 0
//   busy          conversion in progress
//
// state | meaning
// IDLE  | waiting for a coin; countdown runs
// DIV   | divider producing seconds = cents*SCALE/rate
// ADD   | quotient added (saturating) to sec_left, tick folded in
module meter_time_purchase
  import meter_pkg::*;
#(
  parameter int SEC_W  = 12,
  parameter int COIN_W = 8,
  parameter int SCALE  = 6000,
  parameter int DIV_W  = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        sw,
  input  logic              coin_valid,
  input  logic [COIN_W-1:0] coin_cents,
  output logic              coin_ready,
  output logic              coin_reject,
  input  logic              tick_1hz,
  input  logic              clear,
  output logic [SEC_W-1:0]  sec_left,
  output logic              expired,
  output logic              busy
);

  // One bit beyond the quotient so the add can never wrap before clamping.
  localparam int SUM_W = DIV_W + 1;
  localparam logic [SEC_W-1:0] SEC_MAX = {SEC_W{1'b1}};

  purchase_state_t state;

  logic [2:0]       loc;
  logic [4:0]       hour;
  logic             hour_ok;
  logic             div_start;
  logic [DIV_W-1:0] dividend;
  logic [7:0]       rate;
  logic [DIV_W-1:0] quotient;
  logic             div_done;

  logic             dec;
  logic [SUM_W-1:0] sum;
  logic [SEC_W-1:0] sec_next;

  assign loc      = sw[7:5];
  assign hour     = sw[4:0];
  assign hour_ok  = hour_valid(hour);
  assign rate     = rate_lookup(loc, hour);
  assign dividend = DIV_W'(coin_cents) * DIV_W'(SCALE);

  // The divider captures dividend and rate at acceptance, so later sw
  // changes cannot disturb the conversion in flight.
  assign div_start = (state == ST_IDLE) && coin_valid && hour_ok && !clear;

  seq_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (clear),
    .dividend (dividend),
    .divisor  (rate),
    .quotient (quotient),
    .done     (div_done)
  );

  always_comb begin
    sec_next = sec_left;
    sum      = '0;
    dec      = tick_1hz && (sec_left != '0);
    if (clear) begin
      sec_next = '0;
    end else if (state == ST_ADD) begin
      sum = SUM_W'(sec_left) - SUM_W'(dec) + SUM_W'(quotient);
      if (sum > SUM_W'(SEC_MAX)) sec_next = SEC_MAX;
      else                       sec_next = sum[SEC_W-1:0];
    end else if (dec) begin
      sec_next = sec_left - SEC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sec_left    <= '0;
      expired     <= 1'b1;
      coin_ready  <= 1'b1;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sec_left    <= sec_next;
      expired     <= (sec_next == '0);
      coin_reject <= 1'b0;
      if (clear) begin
        state      <= ST_IDLE;
        coin_ready <= 1'b1;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (coin_valid) begin
              if (hour_ok) begin
                state      <= ST_DIV;
                coin_ready <= 1'b0;
                busy       <= 1'b1;
              end else begin
                coin_reject <= 1'b1;
              end
            end
          end
          ST_DIV: begin
            if (div_done) state <= ST_ADD;
          end
          ST_ADD: begin
            state      <= ST_IDLE;
            coin_ready <= 1'b1;
            busy       <= 1'b0;
          end
          default: begin
            state      <= ST_IDLE;
            coin_ready <= 1'b1;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/meter_time_purchase.md
Name: meter_time_purchase

Overview:
- Inverse of the meter's cost conversion: takes deposited coins and converts cents into purchased parking seconds.
- Converts using the rate for the current location/hour switch setting.
- Accumulates the result into a saturating seconds-remaining counter, which counts down on a 1 Hz tick.
- Sits between the coin-entry logic and the display/expiry logic of the parking meter top level.

Parameters:
- SEC_W, 12, width of seconds-remaining counter (matches sec_count width).
- COIN_W, 8, width of coin value in cents.
- SCALE, 6000, seconds-per-minute × rate fixed-point scale (60 × 100).
- DIV_W, 21, dividend/divider iteration count; must be ≥ bits of (2^COIN_W − 1) × SCALE.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  8  [7:5] location, [4:0] hour (0–23 valid).
- coin_valid  in  1  coin present this cycle.
- coin_cents  in  COIN_W  coin value in cents.
- coin_ready  out  1  block can accept a coin.
- coin_reject  out  1  one-cycle pulse: coin dropped because hour is invalid.
- tick_1hz  in  1  one-cycle pulse per second.
- clear  in  1  synchronous clear of purchased time.
- sec_left  out  SEC_W  purchased seconds remaining.
- expired  out  1  registered: high when sec_left == 0.
- busy  out  1  conversion in progress.

Behaviour:
- Clock, reset and clear:
  - Single clock domain clk.
  - Asynchronous active-low reset rst_n.
  - Reset values: sec_left=0, expired=1, coin_ready=1, coin_reject=0, busy=0, FSM=IDLE.
- Rate table (cents/min × 100), sampled from sw on coin acceptance:
  - Locations 0–5 and 7: hours 0–7 → 100; hours 8–17 → 200; hours 18–23 → 100.
  - Location 6: hours 0–7 → 134; hours 8–12 → 156; hours 13–17 → 178; hours 18–23 → 156.
  - Hours 24–31: invalid.
- FSM states: IDLE, DIV, ADD.
  - IDLE:
    - coin_ready=1.
    - A coin is accepted when coin_valid=1 at a rising edge.
    - If the hour is invalid: raise coin_reject for 1 cycle and stay in IDLE.
    - Otherwise latch dividend = coin_cents × SCALE (DIV_W bits) and divisor = rate (8 bits), then go to DIV.
  - DIV:
    - Restoring radix-2 division, one quotient bit per cycle, exactly DIV_W cycles.
    - busy=1, coin_ready=0; coin_valid is ignored.
    - Then go to ADD.
  - ADD (1 cycle):
    - sec_left ← min(sec_left − dec + q, 2^SEC_W − 1).
    - dec = 1 if tick_1hz and sec_left > 0, else 0.
    - q = floor quotient.
    - Then return to IDLE.
- Latency:
  - Coin accepted at edge N; sec_left updated at edge N+DIV_W+1 (N+22 with defaults).
  - coin_ready is high from the following cycle.
- Countdown (outside ADD):
  - tick_1hz with sec_left > 0 → decrement.
  - sec_left = 0 stays 0 (no wrap).
- expired: registered, equal to (next sec_left == 0); updates on the same edge as sec_left.
- clear:
  - Sets sec_left=0 and aborts any DIV/ADD, returning to IDLE; the coin's time is lost.
  - Has priority over tick and ADD.
- Quotient: always truncated (floor).
- Saturation: internal sum ≥ SEC_W+1 bits; sec_left never wraps.
- sw changes during DIV do not affect the in-flight conversion.
- Reset mid-DIV returns to the reset values immediately (asynchronous).

Decomposition:
- Shared package (meter_pkg):
  - Location/hour band constants: HOUR_8=8, HOUR_13=13, HOUR_18=18, HOUR_24=24.
  - Rate constants: RATE_STD_LO=100, RATE_STD_HI=200, RATE_L6_NIGHT=134, RATE_L6_AM=156, RATE_L6_PM=178.
  - FSM state enum.
  - The rate lookup function. Reuse the same band boundaries as cost conversion so both directions stay consistent.
- Sub-module seq_divider:
  - Parameterised DIV_W dividend, 8-bit divisor.
  - start/done handshake.
  - Used by the FSM's DIV state.

Test Plan:
- Location 0, hour 9, coin 25 from sec_left=0 → after 22 cycles sec_left=750, expired falls on the same edge.
- Location 6, hour 14, coin 25 → sec_left=842 (150000/178 floored); location 0, hour 2, coin 5 → +300.
- Location 0, hour 2, three 100-cent coins → 6000 saturates to 4095 on the first coin; later coins keep 4095.
- Hour 25, coin_valid with 100 → coin_reject pulses 1 cycle, sec_left unchanged, coin_ready stays 1.
- sec_left=10, coin 5 at rate 100, tick_1hz coincident with ADD → sec_left=309; 309 more ticks → sec_left=0, expired=1, further ticks hold 0.
- Assert rst_n low mid-DIV (cycle 10) → all outputs return to reset values asynchronously.
- Assert clear mid-DIV → sec_left=0, FSM in IDLE next cycle, no ADD occurs.
